maxpool2d_stream: RTL and testbench

- 2x2, stride-2 max-pooling stage directly downstream of the 6-input partial-convolution unit.
- Consumes its post-ReLU conv output stream, one pixel per valid cycle in raster order: row-major, one feature map, one channel at a time.
- Emits the pooled feature map in raster order to the next conv layer's input buffer.
- Uses a half-width line buffer, so only one pass over the stream is needed.

---
 rtl/nn_pkg.sv | 18 +
 rtl/pool_line_buf.sv | 35 +++
 rtl/maxpool2d_stream.sv | 97 +++++++++
 tb/tb_maxpool2d_stream.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg
//   Shared definitions for the pooling stage and its neighbours:
//   pixel width, per-layer feature-map sizes and an unsigned max helper.
package nn_pkg;

  localparam int PIX_W    = 16;   // post-ReLU pixel width, unsigned
  localparam int C1_OUT_W = 24;   // conv1 output width
  localparam int C1_OUT_H = 24;   // conv1 output height
  localparam int P1_OUT_W = 12;   // pool1 output width (line-buffer depth)

  // Inputs are post-ReLU, so a plain unsigned compare is sufficient.
  // Ties return the shared value.
  function automatic logic [PIX_W-1:0] umax(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf
//   Simple dual-port half-width line buffer for the 2x2 max-pool stage.
//   Synchronous write, asynchronous read (maps to distributed RAM).
//   Contents are not reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data, combinational from raddr
module pool_line_buf
  import nn_pkg::*;
#(
  parameter int N      = PIX_W,
  parameter int DEPTH  = P1_OUT_W,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [N-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [N-1:0]      rdata
);

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2d_stream.sv
// maxpool2d_stream
//   2x2, stride-2 max-pool over a raster-order pixel stream. The horizontal
//   pair is folded through pair_reg; even rows park their horizontal maxima
//   in a half-width line buffer, odd rows combine with them and emit.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   din_vld    in   input pixel valid (may idle any number of cycles)
//   din        in   input pixel, unsigned
//   dout       out  pooled pixel, held while dout_vld is low
//   dout_vld   out  one-cycle pulse per pooled pixel
//   frame_end  out  with dout_vld on the last pooled pixel of a frame
module maxpool2d_stream
  import nn_pkg::*;
#(
  parameter int N     = PIX_W,
  parameter int IMG_W = C1_OUT_W,
  parameter int IMG_H = C1_OUT_H
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din_vld,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         dout_vld,
  output logic         frame_end
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int DEPTH  = IMG_W / 2;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [COL_W-1:0]  col_cnt;
  logic [ROW_W-1:0]  row_cnt;
  logic [N-1:0]      pair_reg;
  logic [N-1:0]      hmax;
  logic [N-1:0]      lb_rdata;
  logic [ADDR_W-1:0] lb_addr;
  logic              lb_we;
  logic              last_col;
  logic              last_row;
  logic              win_done;

  always_comb begin
    last_col = (col_cnt == COL_W'(IMG_W - 1));
    last_row = (row_cnt == ROW_W'(IMG_H - 1));
    hmax     = umax(pair_reg, din);
    lb_addr  = ADDR_W'(col_cnt >> 1);
    // Frame width is even, so bit 0 of each counter gives its parity.
    lb_we    = din_vld && col_cnt[0] && !row_cnt[0];
    win_done = din_vld && col_cnt[0] &&  row_cnt[0];
  end

  // Even rows only write, odd rows only read: no same-cycle address clash.
  pool_line_buf #(
    .N     (N),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_line_buf (
    .clk  (clk),
    .we   (lb_we),
    .waddr(lb_addr),
    .wdata(hmax),
    .raddr(lb_addr),
    .rdata(lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      pair_reg  <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      dout_vld  <= 1'b0;
      frame_end <= 1'b0;
      if (din_vld) begin
        if (!col_cnt[0]) pair_reg <= din;
        if (win_done) begin
          dout      <= umax(lb_rdata, hmax);
          dout_vld  <= 1'b1;
          frame_end <= last_col && last_row;
        end
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool2d_stream.sv
// Bench for maxpool2d_stream: a 4x4 instance for hand-computed vectors and a
// default 24x24 instance for full-size frames. The driver pushes expected
// outputs (value, frame_end, arrival cycle) into a per-instance queue; monitors
// on the falling edge pop and compare whenever dout_vld is seen.
module tb_maxpool2d_stream;

  typedef struct {
    logic [15:0] d;
    logic        fe;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s, rst_l, vld_s, vld_l;
  logic [15:0] din_s, din_l, dout_s, dout_l;
  logic        ov_s, ov_l, fe_s, fe_l;

  maxpool2d_stream #(.N(16), .IMG_W(4), .IMG_H(4)) dut_s (
    .clk(clk), .rst(rst_s), .din_vld(vld_s), .din(din_s),
    .dout(dout_s), .dout_vld(ov_s), .frame_end(fe_s));

  maxpool2d_stream dut_l (
    .clk(clk), .rst(rst_l), .din_vld(vld_l), .din(din_l),
    .dout(dout_l), .dout_vld(ov_l), .frame_end(fe_l));

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  exp_t        q_s[$], q_l[$];
  logic [15:0] got_s[$], got_l[$];
  logic [15:0] hold_s = '0, hold_l = '0;
  int          nfe_s = 0, nfe_l = 0;
  exp_t        e_s, e_l;

  int          rr[2], cc[2];
  int          ww[2] = '{4, 24};
  int          hh[2] = '{4, 24};
  logic [15:0] fr[2][24][24];
  logic [15:0] sf[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mx(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // Drive one valid pixel at a falling edge; returns at the next falling edge.
  task automatic put(input int k, input logic [15:0] v);
    exp_t e;
    int r, c;
    r = rr[k];
    c = cc[k];
    if (k == 0) begin din_s = v; vld_s = 1'b1; end
    else        begin din_l = v; vld_l = 1'b1; end
    fr[k][r][c] = v;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      e.d   = mx(mx(fr[k][r-1][c-1], fr[k][r-1][c]), mx(fr[k][r][c-1], v));
      e.fe  = (r == hh[k] - 1) && (c == ww[k] - 1);
      e.cyc = cyc + 1;
      if (k == 0) q_s.push_back(e); else q_l.push_back(e);
    end
    cc[k] = c + 1;
    if (cc[k] == ww[k]) begin
      cc[k] = 0;
      rr[k] = (r + 1 == hh[k]) ? 0 : r + 1;
    end
    @(negedge clk);
    if (k == 0) vld_s = 1'b0; else vld_l = 1'b0;
  endtask

  // Idle cycles with garbage on din to show idles change nothing.
  task automatic idle(input int k, input int n);
    if (k == 0) din_s = 16'($urandom); else din_l = 16'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int k);
    if (k == 0) begin rst_s = 1'b1; vld_s = 1'b0; end
    else        begin rst_l = 1'b1; vld_l = 1'b0; end
    @(posedge clk);
    #1;
    if (k == 0) begin rst_s = 1'b0; hold_s = '0; q_s.delete(); end
    else        begin rst_l = 1'b0; hold_l = '0; q_l.delete(); end
    rr[k] = 0;
    cc[k] = 0;
    @(negedge clk);
    if (k == 0) begin
      check("s_reset_dout", dout_s, 0);
      check("s_reset_vld", ov_s, 0);
      check("s_reset_fe", fe_s, 0);
    end else begin
      check("l_reset_dout", dout_l, 0);
      check("l_reset_vld", ov_l, 0);
      check("l_reset_fe", fe_l, 0);
    end
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 8; i++) begin
      if ((k == 0 && q_s.size() == 0) || (k == 1 && q_l.size() == 0)) break;
      @(negedge clk);
    end
    @(negedge clk);
    if (k == 0) check("s_drain_pending", q_s.size(), 0);
    else        check("l_drain_pending", q_l.size(), 0);
  endtask

  task automatic small_frame(input bit gaps);
    got_s.delete();
    nfe_s = 0;
    for (int i = 0; i < 16; i++) begin
      put(0, sf[i]);
      if (gaps) idle(0, 1);
    end
    drain(0);
  endtask

  task automatic expect_small(input string nm, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d);
    logic [15:0] ev[4];
    ev = '{a, b, c, d};
    check({nm, "_count"}, got_s.size(), 4);
    check({nm, "_fe_count"}, nfe_s, 1);
    if (got_s.size() == 4)
      for (int i = 0; i < 4; i++) check({nm, "_value"}, got_s[i], ev[i]);
  endtask

  task automatic big_frame(input int mode, input bit gaps);
    for (int i = 0; i < 576; i++) begin
      case (mode)
        0:       put(1, 16'h7FFF);
        1:       put(1, 16'($urandom_range(0, 16'h7FFE)));
        default: put(1, 16'($urandom));
      endcase
      if (gaps && ($urandom_range(0, 3) == 0)) idle(1, $urandom_range(1, 2));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ov_s) begin
        if (q_s.size() == 0) check("s_extra_output", 1, 0);
        else begin
          e_s = q_s.pop_front();
          check("s_dout", dout_s, e_s.d);
          check("s_frame_end", fe_s, e_s.fe);
          check("s_latency_cycle", cyc, e_s.cyc);
          hold_s = e_s.d;
        end
        got_s.push_back(dout_s);
        if (fe_s) nfe_s++;
      end else begin
        check("s_hold_dout", dout_s, hold_s);
        check("s_fe_without_vld", fe_s, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (ov_l) begin
        if (q_l.size() == 0) check("l_extra_output", 1, 0);
        else begin
          e_l = q_l.pop_front();
          check("l_dout", dout_l, e_l.d);
          check("l_frame_end", fe_l, e_l.fe);
          check("l_latency_cycle", cyc, e_l.cyc);
          hold_l = e_l.d;
        end
        got_l.push_back(dout_l);
        if (fe_l) nfe_l++;
      end else begin
        check("l_hold_dout", dout_l, hold_l);
        check("l_fe_without_vld", fe_l, 0);
      end
    end
  end

  initial begin
    int bad;
    rst_s = 1'b1; rst_l = 1'b1;
    vld_s = 1'b0; vld_l = 1'b0;
    din_s = '0;   din_l = '0;
    @(negedge clk);
    do_reset(0);
    do_reset(1);
    mon_en = 1'b1;

    // 4x4 ramp 0..15, continuous then with gaps
    for (int i = 0; i < 16; i++) sf[i] = 16'(i);
    small_frame(1'b0);
    expect_small("ramp", 16'd5, 16'd7, 16'd13, 16'd15);
    small_frame(1'b1);
    expect_small("ramp_gaps", 16'd5, 16'd7, 16'd13, 16'd15);

    // descending ramp, gapped
    for (int i = 0; i < 16; i++) sf[i] = 16'(15 - i);
    small_frame(1'b1);
    expect_small("down", 16'd15, 16'd13, 16'd7, 16'd5);

    // single 0xFFFF at each position of the top-left window
    foreach (sf[i]) sf[i] = '0;
    sf[0] = 16'hFFFF; small_frame(1'b0); expect_small("peak_tl", 16'hFFFF, 0, 0, 0);
    sf[0] = '0; sf[1] = 16'hFFFF; small_frame(1'b0); expect_small("peak_tr", 16'hFFFF, 0, 0, 0);
    sf[1] = '0; sf[4] = 16'hFFFF; small_frame(1'b0); expect_small("peak_bl", 16'hFFFF, 0, 0, 0);
    sf[4] = '0; sf[5] = 16'hFFFF; small_frame(1'b0); expect_small("peak_br", 16'hFFFF, 0, 0, 0);

    // 24x24: all-0x7FFF frame then a smaller random frame, no gap between
    got_l.delete();
    nfe_l = 0;
    big_frame(0, 1'b0);
    big_frame(1, 1'b0);
    drain(1);
    check("b2b_count", got_l.size(), 288);
    check("b2b_fe_count", nfe_l, 2);
    bad = 0;
    for (int i = 0; i < 144 && i < got_l.size(); i++) if (got_l[i] !== 16'h7FFF) bad++;
    check("tie_7fff_bad", bad, 0);

    // reset after 30 inputs, then a full frame
    for (int i = 0; i < 30; i++) put(1, 16'($urandom));
    do_reset(1);
    got_l.delete();
    nfe_l = 0;
    big_frame(2, 1'b0);
    drain(1);
    check("post_reset_count", got_l.size(), 144);
    check("post_reset_fe_count", nfe_l, 1);

    // three random frames with random idle gaps
    got_l.delete();
    nfe_l = 0;
    for (int f = 0; f < 3; f++) big_frame(2, 1'b1);
    drain(1);
    check("random_count", got_l.size(), 432);
    check("random_fe_count", nfe_l, 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    errs++;
    checks++;
    $display("FAIL watchdog: bench did not complete in time");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
